// File: rtl/ln_stream_sequencer_if.sv
// Stream bundle for ln_stream_sequencer.
//   s_*  : single 32-bit AXI-Stream input from the host DMA.
//   m_*  : shared data plus per-sink one-hot valid/ready/last towards the parameter sinks.
// modport master : the sequencer side (accepts s_*, drives m_*).
// modport slave  : the environment side (drives s_*, accepts m_*).
interface ln_stream_sequencer_if #(
   parameter int unsigned NUM_DEST = 9
);
   logic [31:0]         s_TDATA;
   logic                s_TVALID;
   logic                s_TREADY;
   logic                s_TLAST;
   logic [31:0]         m_TDATA;
   logic [NUM_DEST-1:0] m_TVALID;
   logic [NUM_DEST-1:0] m_TREADY;
   logic [NUM_DEST-1:0] m_TLAST;

   modport master (
      input  s_TDATA, s_TVALID, s_TLAST, m_TREADY,
      output s_TREADY, m_TDATA, m_TVALID, m_TLAST
   );

   modport slave (
      output s_TDATA, s_TVALID, s_TLAST, m_TREADY,
      input  s_TREADY, m_TDATA, m_TVALID, m_TLAST
   );
endinterface

// File: rtl/ln_stream_sequencer.sv
// Descriptor-driven scheduler for the LayerNorm/matmul parameter path.
// Walks a table of (dest, len) segments and routes the input stream to one sink at a time,
// generating a per-segment TLAST and a done pulse when the table has been consumed.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_we/addr/dest/len table write port (ignored unless idle)
//   cfg_count           number of valid entries, sampled on start
//   start               begin a sequence (honoured only when idle)
//   busy, done, err     status; err[0] bad dest id, err[1] TLAST mismatch (sticky)
//   strm                stream bundle (master modport): s_* input, m_* one-hot sinks
//
// Optional feature: define SEQ_TLAST_CHECK_EN to compare s_TLAST against the computed last
// on every accepted beat and flag mismatches in err[1]. Without it, s_TLAST is ignored.
module ln_stream_sequencer #(
   parameter int unsigned NUM_DEST = 9,
   parameter int unsigned DEST_W   = 4,
   parameter int unsigned LEN_W    = 24,
   parameter int unsigned SEQ_AW   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_we,
   input  logic [SEQ_AW-1:0]     cfg_addr,
   input  logic [DEST_W-1:0]     cfg_dest,
   input  logic [LEN_W-1:0]      cfg_len,
   input  logic [SEQ_AW:0]       cfg_count,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            err,
   ln_stream_sequencer_if.master strm
);

   localparam int unsigned Depth = 2 ** SEQ_AW;

   typedef enum logic [1:0] {StIdle, StFetch, StStream, StDrain} state_e;

   state_e               state;
   logic [DEST_W-1:0]    tbl_dest [Depth];
   logic [LEN_W-1:0]     tbl_len  [Depth];
   logic [SEQ_AW:0]      idx;
   logic [SEQ_AW:0]      count;
   logic [DEST_W-1:0]    cur_dest;
   logic [LEN_W-1:0]     cur_len;
   logic [LEN_W-1:0]     beat;
   logic                 out_v;
   logic                 out_last;
   logic [31:0]          out_data;

   logic [DEST_W-1:0]    ent_dest;
   logic [LEN_W-1:0]     ent_len;
   logic                 ent_bad;
   logic [NUM_DEST-1:0]  sel;
   logic                 sel_ready;
   logic                 s_accept;
   logic                 out_pop;
   logic                 beat_last;

   assign ent_dest = tbl_dest[idx[SEQ_AW-1:0]];
   assign ent_len  = tbl_len[idx[SEQ_AW-1:0]];
   assign ent_bad  = 32'(ent_dest) >= NUM_DEST;

   // One-hot select of the current sink; ready of non-selected sinks never matters.
   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < NUM_DEST; i++) begin
         sel[i] = (32'(cur_dest) == i);
      end
   end

   assign sel_ready = |(sel & strm.m_TREADY);
   assign out_pop   = out_v & sel_ready;
   assign beat_last = (beat == cur_len - LEN_W'(1));

   // Ready while the holding register is empty or draining this cycle: one beat per cycle.
   assign strm.s_TREADY = (state == StStream) & (~out_v | sel_ready);
   assign s_accept      = strm.s_TVALID & strm.s_TREADY;

   assign strm.m_TDATA  = out_data;
   assign strm.m_TVALID = out_v ? sel : '0;
   assign strm.m_TLAST  = (out_v & out_last) ? sel : '0;

   // Table contents survive reset on purpose; only the sequencing state is cleared.
   always_ff @(posedge clk) begin
      if (cfg_we && state == StIdle) begin
         tbl_dest[cfg_addr] <= cfg_dest;
         tbl_len[cfg_addr]  <= cfg_len;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= StIdle;
         idx      <= '0;
         count    <= '0;
         cur_dest <= '0;
         cur_len  <= '0;
         beat     <= '0;
         out_v    <= 1'b0;
         out_last <= 1'b0;
         out_data <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= '0;
      end else begin
         done <= 1'b0;
         // Drain first; a simultaneous accept below refills the register.
         if (out_pop) out_v <= 1'b0;

         case (state)
            StIdle: begin
               if (start) begin
                  state <= StFetch;
                  count <= cfg_count;
                  idx   <= '0;
                  err   <= '0;
                  busy  <= 1'b1;
               end
            end
            StFetch: begin
               if (idx == count) begin
                  state <= StIdle;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (ent_len == '0) begin
                  idx <= idx + (SEQ_AW + 1)'(1);
               end else if (ent_bad) begin
                  err[0] <= 1'b1;
                  idx    <= idx + (SEQ_AW + 1)'(1);
               end else begin
                  cur_dest <= ent_dest;
                  cur_len  <= ent_len;
                  beat     <= '0;
                  state    <= StStream;
               end
            end
            StStream: begin
               if (s_accept) begin
                  out_v    <= 1'b1;
                  out_data <= strm.s_TDATA;
                  out_last <= beat_last;
                  beat     <= beat + LEN_W'(1);
`ifdef SEQ_TLAST_CHECK_EN
                  if (strm.s_TLAST != beat_last) err[1] <= 1'b1;
`endif
                  if (beat_last) state <= StDrain;
               end
            end
            StDrain: begin
               if (out_pop) begin
                  idx   <= idx + (SEQ_AW + 1)'(1);
                  state <= StFetch;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ln_stream_sequencer.sv
module tb_ln_stream_sequencer;

   localparam int NUM_DEST = 9;
   localparam int DEST_W   = 4;
   localparam int LEN_W    = 24;
   localparam int SEQ_AW   = 4;

   typedef struct {
      int dest;
      bit last;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_we;
   logic [SEQ_AW-1:0] cfg_addr;
   logic [DEST_W-1:0] cfg_dest;
   logic [LEN_W-1:0]  cfg_len;
   logic [SEQ_AW:0]   cfg_count;
   logic              start;
   logic              busy;
   logic              done;
   logic [1:0]        err;

   ln_stream_sequencer_if #(.NUM_DEST(NUM_DEST)) bus ();

   ln_stream_sequencer #(
      .NUM_DEST(NUM_DEST),
      .DEST_W  (DEST_W),
      .LEN_W   (LEN_W),
      .SEQ_AW  (SEQ_AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_dest (cfg_dest),
      .cfg_len  (cfg_len),
      .cfg_count(cfg_count),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .strm     (bus)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int          sh_dest [16];
   int          sh_len  [16];
   exp_t        exp_q [$];
   logic [31:0] in_q [$];
   logic [31:0] out_log [$];
   bit          src_last [$];
   int          last_beats [$];
   int          sink_beats [NUM_DEST];
   int          beat_cnt  = 0;
   int          done_cnt  = 0;
   logic [1:0]  exp_err   = 2'b00;
   bit          mon_en    = 1'b0;
   int          ready_mode = 0;
   bit          tgl = 1'b0;
   bit          acc_prev;
   logic [31:0] acc_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Sink ready patterns: all ready, random, or sink 1 toggling every cycle.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: bus.m_TREADY = '1;
         1: bus.m_TREADY = NUM_DEST'($urandom);
         default: begin
            tgl = ~tgl;
            bus.m_TREADY = '1;
            bus.m_TREADY[1] = tgl;
         end
      endcase
   end

   // Compare process: every output transfer must be the next input beat, routed to the
   // next expected sink with the expected last flag.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         check("onehot_valid", 64'($countones(bus.m_TVALID) <= 1), 1);
         check("last_subset", 64'((bus.m_TLAST & ~bus.m_TVALID) == '0), 1);
         if (!busy) check("ready_idle", bus.s_TREADY, 0);
         if (bus.m_TVALID != '0 && (bus.m_TVALID & bus.m_TREADY) == '0)
            check("stall_ready", bus.s_TREADY, 0);
         if (acc_prev) begin
            check("lat_valid", 64'(bus.m_TVALID != '0), 1);
            check("lat_data", bus.m_TDATA, acc_data);
         end
         acc_prev = bus.s_TVALID && bus.s_TREADY;
         acc_data = bus.s_TDATA;
         if (acc_prev) in_q.push_back(bus.s_TDATA);
         for (int i = 0; i < NUM_DEST; i++) begin
            if (bus.m_TVALID[i] && bus.m_TREADY[i]) begin
               if (exp_q.size() == 0 || in_q.size() == 0) begin
                  fail("extra_beat", i, exp_q.size());
               end else begin
                  exp_t e;
                  logic [31:0] d;
                  e = exp_q.pop_front();
                  d = in_q.pop_front();
                  check("dest", i, e.dest);
                  check("last", bus.m_TLAST[i], e.last);
                  check("data", bus.m_TDATA, d);
               end
               beat_cnt++;
               sink_beats[i]++;
               out_log.push_back(bus.m_TDATA);
               if (bus.m_TLAST[i]) last_beats.push_back(beat_cnt);
            end
         end
         if (done) begin
            done_cnt++;
            check("done_drained", exp_q.size(), 0);
            check("done_err", err, exp_err);
            check("done_busy", busy, 0);
         end
      end else begin
         acc_prev = 1'b0;
      end
   end

   task automatic write_entry(input int a, input int d, input int l);
      @(posedge clk); #1;
      cfg_we = 1'b1;
      cfg_addr = SEQ_AW'(a);
      cfg_dest = DEST_W'(d);
      cfg_len = LEN_W'(l);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      sh_dest[a] = d;
      sh_len[a] = l;
   endtask

   task automatic drive_source(input int n, input bit cnt_data, input int inj, input int abort_at);
      int b = 0;
      int guard = 0;
      bit acc;
      logic [31:0] d;
      d = cnt_data ? 32'd0 : $urandom;
      while (b < n && b != abort_at) begin
         bus.s_TVALID = ($urandom_range(0, 3) != 0);
         bus.s_TDATA = d;
`ifdef SEQ_TLAST_CHECK_EN
         bus.s_TLAST = src_last[b] ^ (b == inj);
`else
         bus.s_TLAST = (b == inj) ? 1'b1 : 1'($urandom);
`endif
         @(negedge clk);
         acc = bus.s_TVALID && bus.s_TREADY;
         @(posedge clk); #1;
         if (acc) begin
            b++;
            d = cnt_data ? 32'(b) : $urandom;
         end
         guard++;
         if (guard > 4000) begin
            fail("src_timeout", b, n);
            break;
         end
      end
      bus.s_TVALID = 1'b0;
   endtask

   // Model: flatten the shadow table into the per-beat (dest, last) list the sinks must see.
   task automatic run_seq(input int cnt, input bit cnt_data, input int inj, input bit tchk,
                          input int abort_at);
      int n;
      int d0;
      int guard;
      exp_q.delete();
      in_q.delete();
      src_last.delete();
      out_log.delete();
      last_beats.delete();
      exp_err = 2'b00;
      beat_cnt = 0;
      foreach (sink_beats[i]) sink_beats[i] = 0;
      for (int k = 0; k < cnt; k++) begin
         if (sh_len[k] != 0) begin
            if (sh_dest[k] >= NUM_DEST) exp_err[0] = 1'b1;
            else begin
               for (int j = 0; j < sh_len[k]; j++) begin
                  exp_t e;
                  e.dest = sh_dest[k];
                  e.last = (j == sh_len[k] - 1);
                  exp_q.push_back(e);
                  src_last.push_back(e.last);
               end
            end
         end
      end
      n = exp_q.size();
`ifdef SEQ_TLAST_CHECK_EN
      if (inj >= 0 && inj < n) exp_err[1] = 1'b1;
`endif
      d0 = done_cnt;
      cfg_count = (SEQ_AW + 1)'(cnt);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      if (tchk) begin
         check("t1_busy", busy, 1);
         check("t1_ready", bus.s_TREADY, 0);
         check("t1_done", done, 0);
      end
      @(negedge clk);
      if (tchk) check("t2_ready", bus.s_TREADY, 1);
      @(posedge clk); #1;
      drive_source(n, cnt_data, inj, abort_at);
      if (abort_at >= 0) return;
      guard = 0;
      while (done_cnt == d0 && guard < 3000) begin
         @(posedge clk);
         guard++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("done_count", done_cnt - d0, 1);
      check("beats", beat_cnt, n);
   endtask

   initial begin
      int d0;
      rst_n = 1'b0;
      cfg_we = 1'b0;
      cfg_addr = '0;
      cfg_dest = '0;
      cfg_len = '0;
      cfg_count = '0;
      start = 1'b0;
      bus.s_TVALID = 1'b0;
      bus.s_TDATA = '0;
      bus.s_TLAST = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_sready", bus.s_TREADY, 0);
      check("rst_mvalid", bus.m_TVALID, 0);
      check("rst_mlast", bus.m_TLAST, 0);
      check("rst_mdata", bus.m_TDATA, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      mon_en = 1'b1;

      // Three segments, all sinks ready: lasts at global beats 16, 17, 21.
      write_entry(0, 1, 16);
      write_entry(1, 2, 1);
      write_entry(2, 8, 4);
      ready_mode = 0;
      run_seq(3, 1'b0, -1, 1'b1, -1);
      check("t1_nlast", last_beats.size(), 3);
      if (last_beats.size() == 3) begin
         check("t1_last0", last_beats[0], 16);
         check("t1_last1", last_beats[1], 17);
         check("t1_last2", last_beats[2], 21);
      end
      check("t1_sink1", sink_beats[1], 16);
      check("t1_sink2", sink_beats[2], 1);
      check("t1_sink8", sink_beats[8], 4);

      // Sink 1 ready toggling, counter data.
      ready_mode = 2;
      write_entry(0, 1, 16);
      run_seq(1, 1'b1, -1, 1'b0, -1);
      check("t2_n", out_log.size(), 16);
      for (int k = 0; k < 16 && k < out_log.size(); k++) check("t2_order", out_log[k], k);

      // Zero-length skip and bad destination.
      ready_mode = 0;
      write_entry(0, 3, 0);
      write_entry(1, 12, 2);
      write_entry(2, 4, 2);
      run_seq(3, 1'b0, -1, 1'b0, -1);
      check("t3_err", err, 2'b01);
      check("t3_sink4", sink_beats[4], 2);
      check("t3_beats", beat_cnt, 2);

      // Early TLAST on beat 3 of 4.
      write_entry(0, 0, 4);
      run_seq(1, 1'b0, 2, 1'b0, -1);
`ifdef SEQ_TLAST_CHECK_EN
      check("t4_err", err, 2'b10);
`else
      check("t4_err", err, 2'b00);
`endif
      check("t4_sink0", sink_beats[0], 4);

      // Empty table: done two cycles after start.
      exp_q.delete();
      exp_err = 2'b00;
      d0 = done_cnt;
      cfg_count = '0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("t5_done1", done, 0);
      check("t5_busy1", busy, 1);
      @(negedge clk);
      check("t5_done2", done, 1);
      check("t5_busy2", busy, 0);
      @(negedge clk);
      check("t5_done3", done, 0);
      check("t5_count", done_cnt - d0, 1);

      // Reset in the middle of a 16-beat segment.
      write_entry(0, 5, 16);
      run_seq(1, 1'b0, -1, 1'b0, 5);
      d0 = done_cnt;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("t6_mvalid", bus.m_TVALID, 0);
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_sready", bus.s_TREADY, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      check("t6_nodone", done_cnt - d0, 0);
      run_seq(1, 1'b0, -1, 1'b0, -1);
      check("t6_sink5", sink_beats[5], 16);

      // Start and table write while busy must both be ignored.
      write_entry(0, 5, 6);
      write_entry(1, 6, 3);
      fork
         run_seq(2, 1'b0, -1, 1'b0, -1);
         begin
            repeat (6) @(posedge clk);
            #1;
            start = 1'b1;
            cfg_we = 1'b1;
            cfg_addr = '0;
            cfg_dest = 4'd7;
            cfg_len = 24'd1;
            @(posedge clk); #1;
            start = 1'b0;
            cfg_we = 1'b0;
         end
      join
      check("t7_sink5", sink_beats[5], 6);
      run_seq(2, 1'b0, -1, 1'b0, -1);
      check("t7_rb_sink5", sink_beats[5], 6);
      check("t7_rb_sink6", sink_beats[6], 3);
      check("t7_rb_sink7", sink_beats[7], 0);

      // Random tables and sink ready patterns.
      for (int it = 0; it < 8; it++) begin
         int cnt;
         cnt = $urandom_range(0, 6);
         for (int k = 0; k < cnt; k++) write_entry(k, $urandom_range(0, 11), $urandom_range(0, 5));
         ready_mode = $urandom_range(0, 1);
         run_seq(cnt, 1'b0, -1, 1'b0, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ln_stream_sequencer.md
# ln_stream_sequencer

Descriptor-driven scheduler for the LayerNorm/matmul parameter path. It walks a programmable table of (destination, length) segments and routes one incoming 32-bit AXI-Stream to one of NUM_DEST parameter sinks at a time. It generates a per-segment TLAST for each sink and pulses done when the whole table has been consumed. It sits between the host DMA stream and the per-parameter slave ports of the mm_ln wrapper, replacing fixed hard-coded load orders with a runtime-loadable sequence.

## Interface
- NUM_DEST, 9: number of destination sink ports.
- DEST_W, 4: destination id width; must satisfy 2^DEST_W >= NUM_DEST.
- LEN_W, 24: segment length width, in beats.
- SEQ_AW, 4: table address width; table depth is 2^SEQ_AW.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_we  in  1  table write strobe; ignored while busy.
- cfg_addr  in  SEQ_AW  table entry index.
- cfg_dest  in  DEST_W  destination id for the entry.
- cfg_len  in  LEN_W  beat count for the entry; 0 means skip.
- cfg_count  in  SEQ_AW+1  number of valid entries; sampled on start.
- start  in  1  begin a sequence; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sequence completes.
- err  out  2  sticky error flags: bit0 = bad destination id, bit1 = TLAST mismatch. Cleared on an accepted start.
- s_TDATA  in  32  input stream data.
- s_TVALID  in  1  input valid.
- s_TREADY  out  1  input ready.
- s_TLAST  in  1  input last; used only with the configuration macro.
- m_TDATA  out  32  registered data, shared by all sinks.
- m_TVALID  out  NUM_DEST  one-hot valid.
- m_TREADY  in  NUM_DEST  per-sink ready.
- m_TLAST  out  NUM_DEST  one-hot last.

## Operation
- Table: 2^SEQ_AW entries of {dest, len}, held in registers and written by cfg_we. Contents are not cleared by reset.
- FSM states: IDLE, FETCH, STREAM, DRAIN.
- IDLE -> FETCH on start. This latches cfg_count, sets idx=0 and clears err.
- FETCH, when idx == count: go to IDLE and pulse done.
- FETCH, when len == 0: idx++ and stay in FETCH.
- FETCH, when dest >= NUM_DEST: set err[0], idx++ and stay in FETCH.
- FETCH, otherwise: load cur_dest and cur_len, set beat=0, go to STREAM.
- STREAM: accept beats into a one-entry output register. s_TREADY = (~out_v | m_TREADY[cur_dest]), only in STREAM.
- STREAM, on each accepted beat: beat++. The register captures {data, last = (beat == cur_len-1)}.
- STREAM, on acceptance of the last beat: go to DRAIN and drop s_TREADY.
- DRAIN: wait until the output register empties (m_TREADY[cur_dest] & out_v), then idx++ and go to FETCH.
- Output routing: m_TVALID[i] = out_v & (i == cur_dest), and m_TLAST[i] likewise. Non-selected sinks see 0. m_TDATA is driven whenever out_v is high.
- Simultaneous drain and fill in STREAM: full throughput, one beat per cycle.
- A sink's ready is ignored unless that sink is selected.
- Reset mid-sequence aborts immediately: the output register is emptied, the FSM returns to IDLE, and no done pulse is produced.

## Timing
- Reset values: busy=0, done=0, err=0, s_TREADY=0, m_TVALID=0, m_TLAST=0, m_TDATA=0.
- Start sampled at edge T: FETCH at T+1, STREAM at T+2. s_TREADY is first able to go high at T+2.
- Data latency: an input beat accepted at edge T appears on m_* from T+1.
- FETCH costs one cycle per table entry, including skipped entries.
- Segment-to-segment gap: at least 2 idle cycles (DRAIN plus FETCH).
- done fires in the cycle the FSM enters IDLE; busy falls in the same cycle.
- cfg_count = 0: done fires 2 cycles after start.

## Configuration
- SEQ_TLAST_CHECK_EN defined: on every accepted input beat, s_TLAST is compared with the computed last. A mismatch sets err[1]. Data routing is unaffected.
- SEQ_TLAST_CHECK_EN undefined: s_TLAST is ignored and err[1] is tied to 0.

## Test plan
- Three-entry table {d1,len 16},{d2,len 1},{d8,len 4}, all sinks ready: 21 beats routed in order; m_TLAST on beats 16, 17 and 21 at the matching sink; one done pulse.
- Sink 1 ready toggling 1010: no beat lost or duplicated, and s_TREADY stalls correctly. Verify data order with counter data 0..15.
- Entries {d3,len 0},{d12,len 2},{d4,len 2}: only sink 4 sees traffic; err = 2'b01.
- With SEQ_TLAST_CHECK_EN defined, assert s_TLAST on beat 3 of a 4-beat segment: err[1] = 1 and all 4 beats are still delivered.
- Assert rst_n low while STREAM is on beat 5 of 16: all m_TVALID = 0 and busy = 0 on the next cycle. A new start after reset completes normally.
- Issue start while busy, and cfg_we while busy: both are ignored, and the table readback via a second run is unchanged.
